// File: rtl/stream_arb_2to1.sv
// -----------------------------------------------------------------------------
// stream_arb_2to1
//
// Packet-aware round-robin arbiter for two 64-bit LArPix word streams. It sits
// directly upstream of the 2:1 data mux and drives that mux's SEL line. A grant
// is held until the granted source finishes its burst with LAST, or until it
// has stalled (VALID low) for TIMEOUT granted cycles. Words from the granted
// source pass through one registered output stage with a valid/ready handshake.
// Loading a new word while the held word drains is allowed, so the output can
// run at one word per cycle.
//
// Parameters
//   WIDTH      data word width
//   TIMEOUT    granted cycles with VALID low before the grant is revoked (1..65535)
//   CNT_WIDTH  width of the optional per-source accepted-word counters
//
// Ports
//   CLK, RST                      clock; asynchronous active-high reset
//   I0_DATA/VALID/LAST, I0_READY  source 0 stream
//   I1_DATA/VALID/LAST, I1_READY  source 1 stream
//   O_DATA/VALID/LAST, O_READY    forwarded stream (registered)
//   SEL                           current grant, 0 = I0, 1 = I1 (downstream mux select)
//   BUSY                          high while a source holds the grant
//   O_CNT0, O_CNT1                accepted-word counters (only with the macro below)
//
// Build option
//   STREAM_ARB_WORD_CNT_EN  adds O_CNT0/O_CNT1, wrapping counts of accepted words
//
// State table
//   state      | meaning
//   ST_IDLE    | no grant; both READYs low; picks the next source
//   ST_GRANT0  | source 0 owns the output register
//   ST_GRANT1  | source 1 owns the output register
// -----------------------------------------------------------------------------
module stream_arb_2to1 #(
    parameter int WIDTH     = 64,
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,

    input  logic [WIDTH-1:0] I0_DATA,
    input  logic             I0_VALID,
    input  logic             I0_LAST,
    output logic             I0_READY,

    input  logic [WIDTH-1:0] I1_DATA,
    input  logic             I1_VALID,
    input  logic             I1_LAST,
    output logic             I1_READY,

    output logic [WIDTH-1:0] O_DATA,
    output logic             O_VALID,
    output logic             O_LAST,
    input  logic             O_READY,

    output logic             SEL,
    output logic             BUSY
`ifdef STREAM_ARB_WORD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] O_CNT0,
    output logic [CNT_WIDTH-1:0] O_CNT1
`endif
);

    // Parameter sanity, evaluated at elaboration only.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("stream_arb_2to1: TIMEOUT must be in 1..65535");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("stream_arb_2to1: CNT_WIDTH must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    // The stall counter revokes the grant on the cycle it would reach TIMEOUT.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             rr_q, rr_d;          // source served last: 0 = I0, 1 = I1
    logic [15:0]      to_cnt_q, to_cnt_d;
    logic             o_valid_q, o_valid_d;
    logic             o_last_q, o_last_d;
    logic [WIDTH-1:0] o_data_q, o_data_d;

    logic             out_free;
    logic             rdy0, rdy1;
    logic             acc0, acc1;

    // Next-state and handshake logic
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        to_cnt_d = to_cnt_q;
        rdy0     = 1'b0;
        rdy1     = 1'b0;
        acc0     = 1'b0;
        acc1     = 1'b0;

        // The output register can take a word if it is empty or draining now.
        out_free = !o_valid_q || O_READY;

        unique case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (I0_VALID && I1_VALID) begin
                    // Both requesting: favour the one not served last.
                    if (rr_q == 1'b0) begin
                        state_d = ST_GRANT1;
                        sel_d   = 1'b1;
                    end else begin
                        state_d = ST_GRANT0;
                        sel_d   = 1'b0;
                    end
                end else if (I0_VALID) begin
                    state_d = ST_GRANT0;
                    sel_d   = 1'b0;
                end else if (I1_VALID) begin
                    state_d = ST_GRANT1;
                    sel_d   = 1'b1;
                end
            end

            ST_GRANT0: begin
                rdy0 = out_free;
                acc0 = I0_VALID && rdy0;
                if (acc0) begin
                    to_cnt_d = '0;
                    if (I0_LAST) begin
                        state_d = ST_IDLE;
                        rr_d    = 1'b0;
                    end
                end else if (!I0_VALID) begin
                    if (to_cnt_q == TO_LAST) begin
                        state_d  = ST_IDLE;
                        rr_d     = 1'b0;
                        to_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
                end
            end

            ST_GRANT1: begin
                rdy1 = out_free;
                acc1 = I1_VALID && rdy1;
                if (acc1) begin
                    to_cnt_d = '0;
                    if (I1_LAST) begin
                        state_d = ST_IDLE;
                        rr_d    = 1'b1;
                    end
                end else if (!I1_VALID) begin
                    if (to_cnt_q == TO_LAST) begin
                        state_d  = ST_IDLE;
                        rr_d     = 1'b1;
                        to_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                to_cnt_d = '0;
            end
        endcase
    end

    // Output register next value; a load takes priority over a drain.
    always_comb begin
        o_valid_d = o_valid_q;
        o_last_d  = o_last_q;
        o_data_d  = o_data_q;
        if (acc0) begin
            o_valid_d = 1'b1;
            o_last_d  = I0_LAST;
            o_data_d  = I0_DATA;
        end else if (acc1) begin
            o_valid_d = 1'b1;
            o_last_d  = I1_LAST;
            o_data_d  = I1_DATA;
        end else if (O_READY) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            rr_q      <= 1'b0;
            to_cnt_q  <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            to_cnt_q  <= to_cnt_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            o_data_q  <= o_data_d;
        end
    end

`ifdef STREAM_ARB_WORD_CNT_EN
    logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q;

    // Free-running counts; they wrap from all-ones back to zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (acc0) begin
                cnt0_q <= cnt0_q + CNT_WIDTH'(1);
            end
            if (acc1) begin
                cnt1_q <= cnt1_q + CNT_WIDTH'(1);
            end
        end
    end

    assign O_CNT0 = cnt0_q;
    assign O_CNT1 = cnt1_q;
`endif

    assign I0_READY = rdy0;
    assign I1_READY = rdy1;
    assign O_DATA   = o_data_q;
    assign O_VALID  = o_valid_q;
    assign O_LAST   = o_last_q;
    assign SEL      = sel_q;
    assign BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stream_arb_2to1.sv
// Testbench for stream_arb_2to1 (TIMEOUT=4, CNT_WIDTH=3). Source drivers feed
// words from per-source queues; the expected output order of every scenario is
// written out by hand into a scoreboard queue and checked by a monitor.
module tb_stream_arb_2to1;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } word_t;

    logic        CLK;
    logic        RST;
    logic [63:0] I0_DATA, I1_DATA, O_DATA;
    logic        I0_VALID, I0_LAST, I0_READY;
    logic        I1_VALID, I1_LAST, I1_READY;
    logic        O_VALID, O_LAST, O_READY;
    logic        SEL, BUSY;
`ifdef STREAM_ARB_WORD_CNT_EN
    logic [2:0]  O_CNT0, O_CNT1;
`endif

    stream_arb_2to1 #(
        .WIDTH    (64),
        .TIMEOUT  (4),
        .CNT_WIDTH(3)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .I0_DATA (I0_DATA),
        .I0_VALID(I0_VALID),
        .I0_LAST (I0_LAST),
        .I0_READY(I0_READY),
        .I1_DATA (I1_DATA),
        .I1_VALID(I1_VALID),
        .I1_LAST (I1_LAST),
        .I1_READY(I1_READY),
        .O_DATA  (O_DATA),
        .O_VALID (O_VALID),
        .O_LAST  (O_LAST),
        .O_READY (O_READY),
        .SEL     (SEL),
        .BUSY    (BUSY)
`ifdef STREAM_ARB_WORD_CNT_EN
        ,
        .O_CNT0  (O_CNT0),
        .O_CNT1  (O_CNT1)
`endif
    );

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    word_t q0[$];
    word_t q1[$];
    word_t expq[$];
    logic  en0 = 1'b0;
    logic  en1 = 1'b0;
    int    pop_cyc[$];
    logic  g_sel[$];
    int    g_idle[$];
    int    g_cyc[$];
    int    idle_run = 0;
    logic  busy_prev = 1'b0;
    word_t sb_e;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic src_burst(input int src, input logic [63:0] base, input int n, input logic last_end);
        for (int i = 0; i < n; i++) begin
            word_t w;
            w.d = base + 64'(i);
            w.l = last_end && (i == n - 1);
            if (src == 0) q0.push_back(w);
            else          q1.push_back(w);
        end
    endtask

    task automatic exp_burst(input logic [63:0] base, input int n, input logic last_end);
        for (int i = 0; i < n; i++) begin
            word_t w;
            w.d = base + 64'(i);
            w.l = last_end && (i == n - 1);
            expq.push_back(w);
        end
    endtask

    task automatic clear_logs();
        pop_cyc.delete();
        g_sel.delete();
        g_idle.delete();
        g_cyc.delete();
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge CLK);
            if (q0.size() == 0 && q1.size() == 0 && expq.size() == 0 && !BUSY && !O_VALID)
                done = 1'b1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s: drain timed out, got %0d words pending, expected 0", name, expq.size());
        end
        en0 = 1'b0;
        en1 = 1'b0;
    endtask

    // Source 0 driver
    initial begin : drv0
        logic f;
        I0_VALID = 1'b0; I0_DATA = '0; I0_LAST = 1'b0;
        forever begin
            @(negedge CLK);
            f = I0_VALID && I0_READY;
            @(posedge CLK); #1;
            if (f && q0.size() > 0) void'(q0.pop_front());
            if (en0 && q0.size() > 0) begin
                I0_VALID = 1'b1; I0_DATA = q0[0].d; I0_LAST = q0[0].l;
            end else begin
                I0_VALID = 1'b0; I0_DATA = '0; I0_LAST = 1'b0;
            end
        end
    end

    // Source 1 driver
    initial begin : drv1
        logic f;
        I1_VALID = 1'b0; I1_DATA = '0; I1_LAST = 1'b0;
        forever begin
            @(negedge CLK);
            f = I1_VALID && I1_READY;
            @(posedge CLK); #1;
            if (f && q1.size() > 0) void'(q1.pop_front());
            if (en1 && q1.size() > 0) begin
                I1_VALID = 1'b1; I1_DATA = q1[0].d; I1_LAST = q1[0].l;
            end else begin
                I1_VALID = 1'b0; I1_DATA = '0; I1_LAST = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every word taken downstream must be the next expected one.
    always @(negedge CLK) begin
        if (!RST && O_VALID && O_READY) begin
            pop_cyc.push_back(cyc);
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_extra: got word 0x%0h, expected none", O_DATA);
            end else begin
                sb_e = expq.pop_front();
                chk("sb_data", O_DATA, sb_e.d);
                chk("sb_last", {63'd0, O_LAST}, {63'd0, sb_e.l});
            end
        end
    end

    // Grant log and per-cycle READY exclusivity
    always @(negedge CLK) begin
        if (RST) begin
            busy_prev = 1'b0;
            idle_run  = 0;
        end else begin
            if (BUSY && !busy_prev) begin
                g_sel.push_back(SEL);
                g_idle.push_back(idle_run);
                g_cyc.push_back(cyc);
            end
            if (BUSY) begin
                idle_run = 0;
                chk("ready_excl", {62'd0, I0_READY && SEL, I1_READY && !SEL}, 64'd0);
            end else begin
                idle_run++;
                chk("idle_ready", {62'd0, I0_READY, I1_READY}, 64'd0);
            end
            busy_prev = BUSY;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic found;
        int   cnt;
        RST     = 1'b1;
        O_READY = 1'b1;

        // Reset values
        #2;
        chk("rst_o_valid", {63'd0, O_VALID}, 64'd0);
        chk("rst_o_last",  {63'd0, O_LAST},  64'd0);
        chk("rst_o_data",  O_DATA, 64'd0);
        chk("rst_sel_busy", {62'd0, SEL, BUSY}, 64'd0);
        chk("rst_readys", {62'd0, I0_READY, I1_READY}, 64'd0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        // 1: I0 alone, A0..A2
        @(posedge CLK); #1;
        clear_logs();
        src_burst(0, 64'hA0, 3, 1'b1);
        exp_burst(64'hA0, 3, 1'b1);
        en0 = 1'b1;
        wait_idle("t1_drain", 40);
        chk("t1_ngrants", 64'(g_sel.size()), 64'd1);
        chk("t1_npops", 64'(pop_cyc.size()), 64'd3);
        if (g_sel.size() >= 1 && pop_cyc.size() >= 3) begin
            chk("t1_sel", {63'd0, g_sel[0]}, 64'd0);
            chk("t1_latency", 64'(pop_cyc[0] - g_cyc[0]), 64'd1);
            chk("t1_gap01", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
            chk("t1_gap12", 64'(pop_cyc[2] - pop_cyc[1]), 64'd1);
        end
        chk("t1_idle_after", {63'd0, BUSY}, 64'd0);

        // 2: both sources, two 2-word bursts each; I1 wins first (I0 served last)
        @(posedge CLK); #1;
        clear_logs();
        src_burst(1, 64'hC0, 2, 1'b1);
        src_burst(1, 64'hC2, 2, 1'b1);
        src_burst(0, 64'hD0, 2, 1'b1);
        src_burst(0, 64'hD2, 2, 1'b1);
        exp_burst(64'hC0, 2, 1'b1);
        exp_burst(64'hD0, 2, 1'b1);
        exp_burst(64'hC2, 2, 1'b1);
        exp_burst(64'hD2, 2, 1'b1);
        en0 = 1'b1;
        en1 = 1'b1;
        wait_idle("t2_drain", 80);
        chk("t2_ngrants", 64'(g_sel.size()), 64'd4);
        if (g_sel.size() >= 4) begin
            chk("t2_grant_order", {60'd0, g_sel[0], g_sel[1], g_sel[2], g_sel[3]}, 64'b1010);
            chk("t2_idle_gap1", 64'(g_idle[1]), 64'd1);
            chk("t2_idle_gap2", 64'(g_idle[2]), 64'd1);
            chk("t2_idle_gap3", 64'(g_idle[3]), 64'd1);
        end

        // 3: downstream stall for 5 cycles while B1 is held
        @(posedge CLK); #1;
        clear_logs();
        src_burst(0, 64'hB0, 4, 1'b1);
        exp_burst(64'hB0, 4, 1'b1);
        en0 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge CLK); #1;
            if (O_VALID && O_DATA == 64'hB1) found = 1'b1;
        end
        chk("t3_reach_b1", {63'd0, found}, 64'd1);
        O_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("t3_hold_valid", {63'd0, O_VALID}, 64'd1);
            chk("t3_hold_data", O_DATA, 64'hB1);
            chk("t3_hold_ready", {63'd0, I0_READY}, 64'd0);
        end
        @(posedge CLK); #1;
        O_READY = 1'b1;
        wait_idle("t3_drain", 40);

        // 4: timeout; I0 sends E0 without LAST then goes quiet, I1 waits
        @(posedge CLK); #1;
        clear_logs();
        src_burst(0, 64'hE0, 1, 1'b0);
        src_burst(1, 64'hF0, 2, 1'b1);
        exp_burst(64'hE0, 1, 1'b0);
        exp_burst(64'hF0, 2, 1'b1);
        en0 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge CLK);
            if (BUSY) found = 1'b1;
        end
        chk("t4_grant0_seen", {62'd0, found, SEL}, 64'b10);
        en1 = 1'b1;
        cnt = 0;
        while (BUSY && !SEL && cnt < 20) begin
            cnt++;
            @(negedge CLK);
        end
        chk("t4_grant0_cycles", 64'(cnt), 64'd5);
        chk("t4_idle_cycle", {63'd0, BUSY}, 64'd0);
        @(negedge CLK);
        chk("t4_grant1", {62'd0, BUSY, SEL}, 64'b11);
        wait_idle("t4_drain", 40);

        // 5: asynchronous reset mid-burst in GRANT1; G1 is dropped
        @(posedge CLK); #1;
        clear_logs();
        src_burst(1, 64'h60, 4, 1'b1);
        exp_burst(64'h60, 1, 1'b0);
        en1 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge CLK); #1;
            if (O_VALID && O_DATA == 64'h61) found = 1'b1;
        end
        chk("t5_reach_g1", {61'd0, found, BUSY, SEL}, 64'b111);
        #2;
        RST = 1'b1;
        en1 = 1'b0;
        q1.delete();
        #1;
        chk("t5_rst_o_valid", {63'd0, O_VALID}, 64'd0);
        chk("t5_rst_o_data", O_DATA, 64'd0);
        chk("t5_rst_o_last", {63'd0, O_LAST}, 64'd0);
        chk("t5_rst_sel_busy", {62'd0, SEL, BUSY}, 64'd0);
        chk("t5_rst_readys", {62'd0, I0_READY, I1_READY}, 64'd0);
        chk("t5_sb_empty", 64'(expq.size()), 64'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // 6: rr pointer back to 0 after reset, so I1 goes first; word counters
        @(posedge CLK); #1;
        clear_logs();
        src_burst(0, 64'h70, 7, 1'b1);
        src_burst(1, 64'h80, 3, 1'b1);
        exp_burst(64'h80, 3, 1'b1);
        exp_burst(64'h70, 7, 1'b1);
        en0 = 1'b1;
        en1 = 1'b1;
        wait_idle("t6_drain", 80);
        chk("t6_ngrants", 64'(g_sel.size()), 64'd2);
        if (g_sel.size() >= 2)
            chk("t6_grant_order", {62'd0, g_sel[0], g_sel[1]}, 64'b10);
`ifdef STREAM_ARB_WORD_CNT_EN
        chk("t6_cnt0", {61'd0, O_CNT0}, 64'd7);
        chk("t6_cnt1", {61'd0, O_CNT1}, 64'd3);
`endif
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        src_burst(0, 64'h90, 9, 1'b1);
        exp_burst(64'h90, 9, 1'b1);
        en0 = 1'b1;
        wait_idle("t6_wrap_drain", 60);
`ifdef STREAM_ARB_WORD_CNT_EN
        chk("t6_cnt0_wrap", {61'd0, O_CNT0}, 64'd1);
        chk("t6_cnt1_zero", {61'd0, O_CNT1}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_arb_2to1.md
Name: stream_arb_2to1

Overview:
- Two-input, packet-aware round-robin arbiter for 64-bit LArPix word streams.
- Sits directly upstream of the 2:1 data mux and drives its SEL line.
- Holds a grant until the granted source ends its burst with LAST, or stalls past a timeout.
- Forwards granted words through one registered output stage with valid/ready handshake.

Parameters:
- WIDTH, 64, data word width in bits.
- TIMEOUT, 16, idle cycles allowed mid-burst before the grant is revoked; 1..65535.
- CNT_WIDTH, 32, width of the optional per-source word counters.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- I0_DATA  input  WIDTH  source 0 word.
- I0_VALID  input  1  source 0 word valid.
- I0_LAST  input  1  source 0 last word of burst.
- I0_READY  output  1  source 0 word accepted this cycle when high with I0_VALID.
- I1_DATA / I1_VALID / I1_LAST / I1_READY: same as the source 0 ports, for source 1.
- O_DATA  output  WIDTH  forwarded word.
- O_VALID  output  1  forwarded word valid.
- O_LAST  output  1  forwarded LAST.
- O_READY  input  1  downstream accepts.
- SEL  output  1  current grant (0 = I0, 1 = I1); drives the downstream mux select.
- BUSY  output  1  high while in a GRANT state.

Behaviour:
- Reset: the asynchronous, active-high RST drives every output to its reset value and the state to IDLE:
  - O_VALID=0, O_LAST=0, O_DATA=0.
  - SEL=0, BUSY=0, I0_READY=0, I1_READY=0.
  - RR pointer=0, timeout counter=0.
- Reset mid-burst drops the held output word; there is no recovery.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - Only I0_VALID: go to GRANT0.
  - Only I1_VALID: go to GRANT1.
  - Both valid: grant the source not served last (RR pointer); pointer 0 means source 0 was served last, so grant source 1.
  - Neither valid: stay.
  - Both READYs are 0 in IDLE.
- GRANTx:
  - SEL=x, BUSY=1.
  - Ix_READY = (!O_VALID || O_READY); the other READY is 0.
  - Accept = Ix_VALID && Ix_READY. On accept, O_DATA/O_LAST load the input and O_VALID=1 next cycle (1-cycle latency).
  - Accept with Ix_LAST=1: next state IDLE, RR pointer=x.
  - Timeout counter clears on each accept and increments on each GRANTx cycle with Ix_VALID=0. When it reaches TIMEOUT, go to IDLE with RR pointer=x; the output register keeps its word.
- Output register: O_VALID clears when O_READY && O_VALID && no new accept in the same cycle. Simultaneous drain and load is allowed, giving full throughput.
- SEL is registered and changes only on the IDLE->GRANT transition. It holds its last value through IDLE.
- First-word latency from VALID in IDLE: 1 cycle to grant, 1 cycle to accept, O_VALID on the cycle after.
- Back-to-back bursts from different sources are separated by exactly one IDLE cycle.
- The non-granted source is never acked, and its VALID is ignored until IDLE.

Optional Feature:
- Macro: STREAM_ARB_WORD_CNT_EN.
- When defined, adds two ports:
  - O_CNT0, output, CNT_WIDTH: count of accepted words from I0.
  - O_CNT1, output, CNT_WIDTH: count of accepted words from I1.
- Each counter increments by 1 per accept, reset value 0, and wraps from all-ones to 0.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then I0 alone, 3 words 0xA0..0xA2 with LAST on 0xA2, O_READY=1 -> SEL=0; O_DATA=0xA0,0xA1,0xA2 on consecutive cycles; O_LAST on 0xA2; IDLE after.
- Both valid from IDLE, each sending 2-word bursts, 4 rounds -> grants alternate 1,0,1,0; no I0 word accepted while SEL=1; one IDLE cycle between bursts.
- O_READY held 0 for 5 cycles mid-burst -> O_VALID and O_DATA stable, Ix_READY=0, no word lost or duplicated; resumes on O_READY=1.
- TIMEOUT=4: I0 sends 1 word without LAST then drops VALID, I1 valid -> after 4 idle cycles, IDLE then GRANT1, SEL=1.
- RST asserted mid-burst in GRANT1 -> all outputs reset immediately (asynchronous), state IDLE, SEL=0.
- STREAM_ARB_WORD_CNT_EN defined: 7 I0 words, 3 I1 words -> O_CNT0=7, O_CNT1=3. With CNT_WIDTH=3 and 9 I0 words -> O_CNT0=1.
